// File: rtl/fetch_stage_if.sv
// Fetch-stage interface bundle: downstream control, instruction-memory port and IF/ID outputs.
interface fetch_stage_if #(
    parameter int unsigned n = 32,
    parameter int unsigned r = 6
);
    logic         stall;
    logic         flush;
    logic         redirect;
    logic [n-1:0] redirect_pc;
    logic [r-1:0] imem_addr;
    logic [n-1:0] imem_rdata;
    logic [n-1:0] pc;
    logic [n-1:0] if_instr;
    logic [n-1:0] if_pc;
    logic [n-1:0] if_pc_plus4;
    logic         if_valid;
    logic         fault;

    // Fetch stage side
    modport master (
        input  stall, flush, redirect, redirect_pc, imem_rdata,
        output imem_addr, pc, if_instr, if_pc, if_pc_plus4, if_valid, fault
    );

    // Pipeline / memory side
    modport slave (
        output stall, flush, redirect, redirect_pc, imem_rdata,
        input  imem_addr, pc, if_instr, if_pc, if_pc_plus4, if_valid, fault
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the async-read instruction memory and
// registers the returned word into the IF/ID pipeline register. Bad PCs halt the stage.
module fetch_stage #(
    parameter int unsigned n        = 32,
    parameter int unsigned r        = 6,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    // First byte address past the end of memory, one bit wider so it never overflows.
    localparam logic [n:0] PcLimit = (n+1)'(1) << (r + 2);

    state_e       state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic [n-1:0] if_instr_q, if_instr_d;
    logic [n-1:0] if_pc_q, if_pc_d;
    logic [n-1:0] if_pc_plus4_q, if_pc_plus4_d;
    logic         if_valid_q, if_valid_d;
    logic         fault_q, fault_d;

    logic [n-1:0] pc_plus4;
    logic         pc_bad;
    logic         redirect_bad;

    assign pc_plus4     = pc_q + n'(4);
    assign pc_bad       = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= PcLimit);
    assign redirect_bad = (bus.redirect_pc[1:0] != 2'b00);

    // Next-state: fault check beats redirect beats stall beats flush beats normal fetch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_valid_d    = if_valid_q;
        fault_d       = fault_q;
        case (state_q)
            StBoot: begin
                state_d    = StRun;
                if_valid_d = 1'b0;
            end
            StRun: begin
                if (pc_bad) begin
                    state_d    = StHalt;
                    fault_d    = 1'b1;
                    if_valid_d = 1'b0;
                end else if (bus.redirect) begin
                    if_valid_d = 1'b0;
                    if (redirect_bad) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = bus.redirect_pc;
                    end
                end else if (bus.stall) begin
                    if (bus.flush) begin
                        if_valid_d = 1'b0;
                    end
                end else if (bus.flush) begin
                    pc_d       = pc_plus4;
                    if_valid_d = 1'b0;
                end else begin
                    pc_d          = pc_plus4;
                    if_instr_d    = bus.imem_rdata;
                    if_pc_d       = pc_q;
                    if_pc_plus4_d = pc_plus4;
                    if_valid_d    = 1'b1;
                end
            end
            StHalt: begin
                if_valid_d = 1'b0;
                fault_d    = 1'b1;
            end
            default: begin
                state_d    = StHalt;
                fault_d    = 1'b1;
                if_valid_d = 1'b0;
            end
        endcase
    end

    // State and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
            if_valid_q    <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_valid_q    <= if_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.imem_addr   = pc_q[r+1:2];
    assign bus.pc          = pc_q;
    assign bus.if_instr    = if_instr_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_pc_plus4 = if_pc_plus4_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;
    logic clk;
    logic reset;
    logic [31:0] mem [64];
    int n_checks;
    int n_bad;

    fetch_stage_if #(.n(32), .r(6)) bus ();

    fetch_stage #(.n(32), .r(6), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_rdata = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
        bus.stall       = st;
        bus.flush       = fl;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pc"}, bus.pc, 32'h0);
        check_eq({tag, "_instr"}, bus.if_instr, 32'h0);
        check_eq({tag, "_ifpc"}, bus.if_pc, 32'h0);
        check_eq({tag, "_ifpc4"}, bus.if_pc_plus4, 32'h0);
        check_eq({tag, "_valid"}, 32'(bus.if_valid), 32'h0);
        check_eq({tag, "_fault"}, 32'(bus.fault), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_bad    = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA0 + 32'(i);
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #22;
        check_reset_vals("rst");
        reset = 1'b0;

        // BOOT bubble
        tick();
        check_eq("boot_valid", 32'(bus.if_valid), 32'h0);
        check_eq("boot_pc", bus.pc, 32'h0);

        // Sequential fetch of words 0..2
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("seq_instr", bus.if_instr, 32'hA0 + 32'(i));
            check_eq("seq_ifpc", bus.if_pc, 32'(4 * i));
            check_eq("seq_ifpc4", bus.if_pc_plus4, 32'(4 * i + 4));
            check_eq("seq_valid", 32'(bus.if_valid), 32'h1);
            check_eq("seq_addr", 32'(bus.imem_addr), 32'(i + 1));
        end

        // Stall three cycles with if_pc=8
        set_ctl(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_pc", bus.pc, 32'hC);
            check_eq("stall_instr", bus.if_instr, 32'hA2);
            check_eq("stall_valid", 32'(bus.if_valid), 32'h1);
        end
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("unstall_ifpc", bus.if_pc, 32'hC);
        check_eq("unstall_instr", bus.if_instr, 32'hA3);
        check_eq("unstall_pc", bus.pc, 32'h10);

        // Redirect wins over stall
        set_ctl(1'b1, 1'b0, 1'b1, 32'h20);
        tick();
        check_eq("redir_pc", bus.pc, 32'h20);
        check_eq("redir_valid", 32'(bus.if_valid), 32'h0);
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("tgt_ifpc", bus.if_pc, 32'h20);
        check_eq("tgt_instr", bus.if_instr, 32'hA8);
        check_eq("tgt_valid", 32'(bus.if_valid), 32'h1);
        check_eq("tgt_pc", bus.pc, 32'h24);

        // Flush with stall, then flush alone
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check_eq("fls_pc", bus.pc, 32'h24);
        check_eq("fls_valid", 32'(bus.if_valid), 32'h0);
        set_ctl(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_eq("fl_pc", bus.pc, 32'h28);
        check_eq("fl_valid", 32'(bus.if_valid), 32'h0);
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("fl_next_valid", 32'(bus.if_valid), 32'h1);
        check_eq("fl_next_ifpc", bus.if_pc, 32'h28);
        check_eq("fl_next_instr", bus.if_instr, 32'hAA);

        // Async reset in RUN at pc=0x14
        set_ctl(1'b0, 1'b0, 1'b1, 32'h14);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("pre_rst_pc", bus.pc, 32'h14);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("arst_run");
        #2;
        reset = 1'b0;
        tick();
        check_eq("reboot_valid", 32'(bus.if_valid), 32'h0);
        tick();
        check_eq("reboot_valid2", 32'(bus.if_valid), 32'h1);
        check_eq("reboot_ifpc", bus.if_pc, 32'h0);
        check_eq("reboot_instr", bus.if_instr, 32'hA0);

        // Misaligned redirect halts; later redirects ignored
        set_ctl(1'b0, 1'b0, 1'b1, 32'h22);
        tick();
        check_eq("mis_fault", 32'(bus.fault), 32'h1);
        check_eq("mis_valid", 32'(bus.if_valid), 32'h0);
        check_eq("mis_pc", bus.pc, 32'h4);
        set_ctl(1'b0, 1'b0, 1'b1, 32'h40);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("halt_pc", bus.pc, 32'h4);
            check_eq("halt_fault", 32'(bus.fault), 32'h1);
            check_eq("halt_valid", 32'(bus.if_valid), 32'h0);
        end
        check_eq("halt_instr", bus.if_instr, 32'hA0);

        // Async reset in HALT
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("arst_halt");
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b0;
        tick();
        check_eq("boot2_valid", 32'(bus.if_valid), 32'h0);

        // Run off the end of memory
        set_ctl(1'b0, 1'b0, 1'b1, 32'hF8);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("end_pc", bus.pc, 32'hF8);
        tick();
        tick();
        check_eq("last_ifpc", bus.if_pc, 32'hFC);
        check_eq("last_instr", bus.if_instr, 32'hA0 + 32'd63);
        check_eq("last_fault", 32'(bus.fault), 32'h0);
        check_eq("oob_pc", bus.pc, 32'h100);
        check_eq("oob_addr", 32'(bus.imem_addr), 32'h0);
        tick();
        check_eq("oob_fault", 32'(bus.fault), 32'h1);
        check_eq("oob_valid", 32'(bus.if_valid), 32'h0);
        check_eq("oob_pc_frozen", bus.pc, 32'h100);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
